spi_master: RTL and testbench

SPI_MASTER -- requirements
Module: spi_master

---
 rtl/spi_pkg.sv | 22 ++
 rtl/sync2.sv | 25 ++
 rtl/spi_master.sv | 222 ++++++++++++++++++++++
 tb/tb_spi_master.sv | 323 ++++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/spi_pkg.sv
// Shared SPI definitions: default geometry, FSM state encoding and helpers.
// Both the master and slave-side logic import this package.
package spi_pkg;

  localparam int unsigned SPI_DATA_W = 32;
  localparam int unsigned SPI_DIV    = 2;
  localparam int unsigned LAST_BIT   = SPI_DATA_W - 1;

  typedef enum logic [2:0] {
    ST_IDLE  = 3'd0,
    ST_SETUP = 3'd1,
    ST_XFER  = 3'd2,
    ST_HOLD  = 3'd3,
    ST_GAP   = 3'd4
  } spi_state_e;

  // Bit counter width that can hold DATA_W itself without wrapping.
  function automatic int unsigned bit_cnt_width(input int unsigned data_w);
    return $clog2(data_w) + 1;
  endfunction

endpackage

// File: rtl/sync2.sv
// Two-flop synchroniser for a single asynchronous input bit.
module sync2 (
  input  logic clk_i,
  input  logic rst_ni,
  input  logic d_i,
  output logic q_o
);

  logic meta_q;
  logic sync_q;

  // Two-stage capture; only sync_q is used by downstream logic.
  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      meta_q <= 1'b0;
      sync_q <= 1'b0;
    end else begin
      meta_q <= d_i;
      sync_q <= meta_q;
    end
  end

  assign q_o = sync_q;

endmodule

// File: rtl/spi_master.sv
// SPI master, mode 0 (CPOL=0, CPHA=0), MSB first, fixed-length words.
// Every pin is driven straight from a flop; one half-period counter paces
// SETUP, XFER, HOLD and GAP so all phase lengths equal DIV osc cycles.
module spi_master
  import spi_pkg::*;
#(
  parameter int unsigned DATA_W = SPI_DATA_W,
  parameter int unsigned DIV    = SPI_DIV
) (
  input  logic              osc,
  input  logic              rst_n,
  input  logic              start,
  input  logic [DATA_W-1:0] tx_data,
  output logic [DATA_W-1:0] rx_data,
  output logic              busy,
  output logic              done,
  output logic              SCK,
  output logic              MOSI,
  input  logic              MISO,
  output logic              SSEL
);

  localparam int unsigned      CNT_W    = 8;
  localparam int unsigned      BC_W     = bit_cnt_width(DATA_W);
  localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(DIV - 1);
  localparam logic [BC_W-1:0]  BIT_LAST = BC_W'(DATA_W - 1);

  spi_state_e        state_q, state_d;
  logic [CNT_W-1:0]  cnt_q, cnt_d;
  logic [BC_W-1:0]   bit_cnt_q, bit_cnt_d;
  logic [DATA_W-1:0] tx_sh_q, tx_sh_d;
  logic [DATA_W-1:0] rx_sh_q, rx_sh_d;
  logic [DATA_W-1:0] rx_data_q, rx_data_d;
  logic              busy_q, busy_d;
  logic              done_q, done_d;
  logic              sck_q, sck_d;
  logic              mosi_q, mosi_d;
  logic              ssel_q, ssel_d;
  logic              miso_s;
  logic              cnt_last_s;
  logic              bit_last_s;

  sync2 u_miso_sync (
    .clk_i  (osc),
    .rst_ni (rst_n),
    .d_i    (MISO),
    .q_o    (miso_s)
  );

  assign cnt_last_s = (cnt_q == CNT_LAST);
  assign bit_last_s = (bit_cnt_q == BIT_LAST);

  // FSM state register.
  always_ff @(posedge osc or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= ST_IDLE;
    end else begin
      state_q <= state_d;
    end
  end

  // Next-state decode: each non-idle phase ends when the half-period counter expires.
  always_comb begin
    state_d = state_q;
    case (state_q)
      ST_IDLE: begin
        if (start) begin
          state_d = ST_SETUP;
        end else begin
          state_d = ST_IDLE;
        end
      end
      ST_SETUP: begin
        if (cnt_last_s) begin
          state_d = ST_XFER;
        end else begin
          state_d = ST_SETUP;
        end
      end
      ST_XFER: begin
        if (cnt_last_s && sck_q && bit_last_s) begin
          state_d = ST_HOLD;
        end else begin
          state_d = ST_XFER;
        end
      end
      ST_HOLD: begin
        if (cnt_last_s) begin
          state_d = ST_GAP;
        end else begin
          state_d = ST_HOLD;
        end
      end
      ST_GAP: begin
        if (cnt_last_s) begin
          state_d = ST_IDLE;
        end else begin
          state_d = ST_GAP;
        end
      end
      default: state_d = ST_IDLE;
    endcase
  end

  // Output and datapath next values; pins change on the same edge as the state.
  always_comb begin
    cnt_d     = cnt_q;
    bit_cnt_d = bit_cnt_q;
    tx_sh_d   = tx_sh_q;
    rx_sh_d   = rx_sh_q;
    rx_data_d = rx_data_q;
    busy_d    = busy_q;
    done_d    = 1'b0;
    sck_d     = sck_q;
    mosi_d    = mosi_q;
    ssel_d    = ssel_q;
    case (state_q)
      ST_IDLE: begin
        cnt_d = '0;
        sck_d = 1'b0;
        if (start) begin
          tx_sh_d   = tx_data;
          rx_sh_d   = '0;
          bit_cnt_d = '0;
          ssel_d    = 1'b0;
          busy_d    = 1'b1;
          mosi_d    = tx_data[DATA_W-1];
        end else begin
          ssel_d = 1'b1;
          busy_d = 1'b0;
          mosi_d = 1'b0;
        end
      end
      ST_SETUP: begin
        if (cnt_last_s) begin
          cnt_d = '0;
          sck_d = 1'b1;
        end else begin
          cnt_d = cnt_q + 8'd1;
        end
      end
      ST_XFER: begin
        if (cnt_last_s) begin
          cnt_d = '0;
          if (sck_q) begin
            // Falling edge: sample MISO, advance MOSI to the next bit.
            sck_d     = 1'b0;
            rx_sh_d   = (rx_sh_q << 1) | DATA_W'(miso_s);
            bit_cnt_d = bit_cnt_q + BC_W'(1);
            tx_sh_d   = tx_sh_q << 1;
            mosi_d    = tx_sh_d[DATA_W-1];
          end else begin
            sck_d = 1'b1;
          end
        end else begin
          cnt_d = cnt_q + 8'd1;
        end
      end
      ST_HOLD: begin
        if (cnt_last_s) begin
          cnt_d     = '0;
          ssel_d    = 1'b1;
          mosi_d    = 1'b0;
          done_d    = 1'b1;
          rx_data_d = rx_sh_q;
        end else begin
          cnt_d = cnt_q + 8'd1;
        end
      end
      ST_GAP: begin
        if (cnt_last_s) begin
          cnt_d  = '0;
          busy_d = 1'b0;
        end else begin
          cnt_d = cnt_q + 8'd1;
        end
      end
      default: begin
        cnt_d  = '0;
        sck_d  = 1'b0;
        ssel_d = 1'b1;
        mosi_d = 1'b0;
        busy_d = 1'b0;
      end
    endcase
  end

  // Datapath and output register bank.
  always_ff @(posedge osc or negedge rst_n) begin
    if (!rst_n) begin
      cnt_q     <= '0;
      bit_cnt_q <= '0;
      tx_sh_q   <= '0;
      rx_sh_q   <= '0;
      rx_data_q <= '0;
      busy_q    <= 1'b0;
      done_q    <= 1'b0;
      sck_q     <= 1'b0;
      mosi_q    <= 1'b0;
      ssel_q    <= 1'b1;
    end else begin
      cnt_q     <= cnt_d;
      bit_cnt_q <= bit_cnt_d;
      tx_sh_q   <= tx_sh_d;
      rx_sh_q   <= rx_sh_d;
      rx_data_q <= rx_data_d;
      busy_q    <= busy_d;
      done_q    <= done_d;
      sck_q     <= sck_d;
      mosi_q    <= mosi_d;
      ssel_q    <= ssel_d;
    end
  end

  assign rx_data = rx_data_q;
  assign busy    = busy_q;
  assign done    = done_q;
  assign SCK     = sck_q;
  assign MOSI    = mosi_q;
  assign SSEL    = ssel_q;

endmodule

// File: tb/tb_spi_master.sv
// Bench for spi_master: a cycle-numbered behavioural model of the transfer
// timeline, a mode-0 slave, and directed plus randomised stimulus.
module tb_spi_master;

  localparam int W = 32;

  logic osc   = 1'b0;
  logic rst_n = 1'b1;

  // DUT A: DIV=2, looped to a model slave
  logic         a_start = 1'b0;
  logic [W-1:0] a_tx    = '0;
  logic [W-1:0] a_rx;
  logic         a_busy, a_done, a_sck, a_mosi, a_miso, a_ssel;
  // DUT B: DIV=5, MISO driven directly
  logic         b_start = 1'b0;
  logic [W-1:0] b_tx    = '0;
  logic [W-1:0] b_rx;
  logic         b_busy, b_done, b_sck, b_mosi, b_ssel;
  logic         b_miso  = 1'b0;

  spi_master #(.DATA_W(W), .DIV(2)) u_dut_a (
    .osc(osc), .rst_n(rst_n), .start(a_start), .tx_data(a_tx), .rx_data(a_rx),
    .busy(a_busy), .done(a_done), .SCK(a_sck), .MOSI(a_mosi), .MISO(a_miso), .SSEL(a_ssel)
  );

  spi_master #(.DATA_W(W), .DIV(5)) u_dut_b (
    .osc(osc), .rst_n(rst_n), .start(b_start), .tx_data(b_tx), .rx_data(b_rx),
    .busy(b_busy), .done(b_done), .SCK(b_sck), .MOSI(b_mosi), .MISO(b_miso), .SSEL(b_ssel)
  );

  always #5 osc = ~osc;

  // Mode-0 slave: presents MSB on SSEL fall, shifts on SCK fall, captures on SCK rise.
  logic [W-1:0] sl_word = '0;
  logic [W-1:0] sl_out  = '0;
  logic [W-1:0] sl_in   = '0;
  logic         stuck_en  = 1'b0;
  logic         stuck_val = 1'b0;

  always @(negedge a_ssel) sl_out = sl_word;
  always @(negedge a_sck)  sl_out = sl_out << 1;
  always @(posedge a_sck)  sl_in  = {sl_in[W-2:0], a_mosi};
  assign a_miso = stuck_en ? stuck_val : (a_ssel ? 1'b0 : sl_out[W-1]);

  int total = 0;
  int bad   = 0;

  task automatic chk1(input string nm, input logic act_v, input logic exp_v);
    total++;
    if (act_v !== exp_v) begin
      bad++;
      $display("FAIL %s: got %b expected %b (t=%0t)", nm, act_v, exp_v, $time);
    end
  endtask

  task automatic chkw(input string nm, input logic [W-1:0] act_v, input logic [W-1:0] exp_v);
    total++;
    if (act_v !== exp_v) begin
      bad++;
      $display("FAIL %s: got %h expected %h (t=%0t)", nm, act_v, exp_v, $time);
    end
  endtask

  task automatic chki(input string nm, input int act_v, input int exp_v);
    total++;
    if (act_v != exp_v) begin
      bad++;
      $display("FAIL %s: got %0d expected %0d", nm, act_v, exp_v);
    end
  endtask

  // Behavioural model: per DUT, the cycle number since accept (1..(2W+2)*DIV
  // while busy) fully determines every pin; rx_data follows the word the
  // slave side offered at accept time.
  int           m_act [2] = '{0, 0};
  int           m_cyc [2] = '{0, 0};
  logic [W-1:0] m_tx  [2];
  logic [W-1:0] m_rx  [2] = '{'0, '0};
  logic [W-1:0] m_nrx [2];

  task automatic model_step(input int id, input int d, input logic st,
                            input logic [W-1:0] txd, input logic [W-1:0] mword,
                            input logic sck, input logic ssel, input logic bsy,
                            input logic dn, input logic mosi, input logic [W-1:0] rx);
    int c;
    int h;
    logic e_ssel;
    logic e_done;
    logic e_sck;
    if (m_act[id] != 0) begin
      c      = m_cyc[id];
      h      = (c - 1) / d;
      e_ssel = (c >= (2*W+1)*d + 1);
      e_done = (c == (2*W+1)*d + 1);
      e_sck  = (h < 2*W) && (h % 2 == 1);
      if (e_done) m_rx[id] = m_nrx[id];
      chk1("sck", sck, e_sck);
      chk1("ssel", ssel, e_ssel);
      chk1("busy", bsy, 1'b1);
      chk1("done", dn, e_done);
      chkw("rx_data", rx, m_rx[id]);
      if (h < 2*W) chk1("mosi_bit", mosi, m_tx[id][W-1-h/2]);
      else if (e_ssel) chk1("mosi_ssel_hi", mosi, 1'b0);
      if (c == (2*W+2)*d) m_act[id] = 0;
      else m_cyc[id] = c + 1;
    end else begin
      chk1("idle_sck", sck, 1'b0);
      chk1("idle_ssel", ssel, 1'b1);
      chk1("idle_busy", bsy, 1'b0);
      chk1("idle_done", dn, 1'b0);
      chk1("idle_mosi", mosi, 1'b0);
      chkw("idle_rx", rx, m_rx[id]);
      if (st) begin
        m_act[id] = 1;
        m_cyc[id] = 1;
        m_tx[id]  = txd;
        m_nrx[id] = mword;
      end
    end
  endtask

  // Compare process: inputs change only just after posedge, so negedge sees settled values.
  always @(negedge osc) begin
    if (rst_n) begin
      model_step(0, 2, a_start, a_tx, stuck_en ? {W{stuck_val}} : sl_word,
                 a_sck, a_ssel, a_busy, a_done, a_mosi, a_rx);
      model_step(1, 5, b_start, b_tx, {W{b_miso}},
                 b_sck, b_ssel, b_busy, b_done, b_mosi, b_rx);
    end
  end

  task automatic cyc();
    @(posedge osc);
    #1;
  endtask

  task automatic wait_a_idle(input int lim);
    int k;
    k = 0;
    while (a_busy && k < lim) begin
      cyc();
      k++;
    end
    chk1("a_idle_timeout", a_busy, 1'b0);
  endtask

  task automatic wait_b_idle(input int lim);
    int k;
    k = 0;
    while (b_busy && k < lim) begin
      cyc();
      k++;
    end
    chk1("b_idle_timeout", b_busy, 1'b0);
  endtask

  initial begin
    int n;
    int rises;
    int first_rise;
    int ssel_first;
    int ssel_last;
    int done_cyc;
    int done_cnt;
    int busy_low;
    int rise_n;
    int fall2_n;
    logic prev_sck;
    logic prev_ssel;
    logic [W-1:0] first_rx;

    #2 rst_n = 1'b0;
    repeat (3) cyc();
    // reset state of both DUTs
    chk1("rst_sck", a_sck, 1'b0);
    chk1("rst_ssel", a_ssel, 1'b1);
    chk1("rst_busy", a_busy, 1'b0);
    chk1("rst_done", a_done, 1'b0);
    chk1("rst_mosi", a_mosi, 1'b0);
    chkw("rst_rx", a_rx, 32'h0000_0000);
    chk1("rst_b_ssel", b_ssel, 1'b1);
    chkw("rst_b_rx", b_rx, 32'h0000_0000);

    // Directed transfer: start already high when reset releases -> accepted on first edge.
    a_tx    = 32'hA5C3_0F81;
    sl_word = 32'h1234_5678;
    a_start = 1'b1;
    rst_n   = 1'b1;
    cyc();
    n = 1; rises = 0; first_rise = -1; ssel_first = -1; ssel_last = -1;
    done_cyc = -1; done_cnt = 0; busy_low = -1; prev_sck = 1'b0;
    while (n < 200 && busy_low < 0) begin
      a_start = (n == 50 || n == 131);
      if (n == 20) a_tx = 32'h5A5A_1234;
      @(negedge osc);
      if (a_sck && !prev_sck) begin
        rises++;
        if (first_rise < 0) first_rise = n;
      end
      prev_sck = a_sck;
      if (!a_ssel) begin
        if (ssel_first < 0) ssel_first = n;
        ssel_last = n;
      end
      if (a_done) begin
        done_cnt++;
        if (done_cyc < 0) done_cyc = n;
      end
      if (!a_busy) busy_low = n;
      cyc();
      n++;
    end
    a_start = 1'b0;
    repeat (4) cyc();
    chki("sck_rises", rises, 32);
    chki("first_rise_cycle", first_rise, 3);
    chki("ssel_first_low", ssel_first, 1);
    chki("ssel_last_low", ssel_last, 130);
    chki("done_cycle", done_cyc, 131);
    chki("done_pulses", done_cnt, 1);
    chki("busy_low_cycle", busy_low, 133);
    chkw("slave_capture", sl_in, 32'hA5C3_0F81);
    chkw("rx_loopback", a_rx, 32'h1234_5678);

    // Randomised transfers on A: stray starts and tx_data churn while busy.
    for (int it = 0; it < 6; it++) begin
      int k;
      wait_a_idle(400);
      repeat ($urandom_range(0, 3)) cyc();
      stuck_en  = (it < 2) ? 1'b1 : ($urandom_range(0, 3) == 0);
      stuck_val = (it == 0) ? 1'b1 : (it == 1) ? 1'b0 : 1'($urandom_range(0, 1));
      sl_word   = $urandom;
      a_tx      = $urandom;
      a_start   = 1'b1;
      cyc();
      k = 0;
      while (a_busy && k < 400) begin
        a_start = ($urandom_range(0, 3) == 0);
        if ($urandom_range(0, 7) == 0) a_tx = $urandom;
        cyc();
        k++;
      end
      a_start = 1'b0;
      chk1("rand_end_timeout", a_busy, 1'b0);
      if (it == 0) chkw("stuck1_rx", a_rx, 32'hFFFF_FFFF);
      if (it == 1) chkw("stuck0_rx", a_rx, 32'h0000_0000);
    end
    stuck_en = 1'b0;
    wait_a_idle(400);

    // DUT B: start held high, back-to-back transfers, MISO 1 then 0.
    b_miso  = 1'b1;
    b_tx    = $urandom;
    b_start = 1'b1;
    cyc();
    n = 1; done_cnt = 0; rise_n = -1; fall2_n = -1; prev_ssel = 1'b0; first_rx = '0;
    while (done_cnt < 2 && n < 1500) begin
      @(negedge osc);
      if (b_ssel && !prev_ssel && rise_n < 0) rise_n = n;
      if (!b_ssel && prev_ssel && rise_n >= 0 && fall2_n < 0) fall2_n = n;
      prev_ssel = b_ssel;
      if (b_done) begin
        done_cnt++;
        if (done_cnt == 1) first_rx = b_rx;
      end
      cyc();
      n++;
      if (done_cnt >= 1) b_miso = 1'b0;
    end
    b_start = 1'b0;
    wait_b_idle(800);
    chki("b_done_pulses", done_cnt, 2);
    chkw("b_first_rx", first_rx, 32'hFFFF_FFFF);
    chkw("b_second_rx", b_rx, 32'h0000_0000);
    total++;
    if (!(rise_n >= 0 && fall2_n - rise_n >= 5)) begin
      bad++;
      $display("FAIL b_ssel_high_time: got %0d expected >= 5", fall2_n - rise_n);
    end

    // Reset in cycle 40 of a transfer: outputs return to idle without an edge.
    wait_a_idle(400);
    sl_word = $urandom;
    a_tx    = $urandom;
    a_start = 1'b1;
    cyc();
    a_start = 1'b0;
    repeat (39) cyc();
    #1 rst_n = 1'b0;
    #1;
    chk1("arst_ssel", a_ssel, 1'b1);
    chk1("arst_sck", a_sck, 1'b0);
    chk1("arst_busy", a_busy, 1'b0);
    chk1("arst_done", a_done, 1'b0);
    chk1("arst_mosi", a_mosi, 1'b0);
    chkw("arst_rx", a_rx, 32'h0000_0000);
    m_act[0] = 0; m_act[1] = 0;
    m_rx[0]  = '0; m_rx[1]  = '0;
    for (int i = 0; i < 3; i++) begin
      @(negedge osc);
      chk1("arst_no_done", a_done, 1'b0);
      chk1("arst_hold_ssel", a_ssel, 1'b1);
    end
    cyc();
    rst_n = 1'b1;

    // One more transfer after the abort.
    repeat (2) cyc();
    sl_word = $urandom;
    a_tx    = $urandom;
    a_start = 1'b1;
    cyc();
    a_start = 1'b0;
    cyc();
    wait_a_idle(400);
    repeat (3) cyc();

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
